// File: rtl/apb_master_8bit.sv
// apb_master_8bit: APB3 initiator. It turns single register commands into
// SETUP/ACCESS transfers, honours pready wait states, and returns one
// response pulse per transfer.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort a transfer after
// TIMEOUT consecutive ACCESS cycles with pready low.
//
// Ports:
//   pclk, preset          clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready combinational on pready)
//   cmd_write/addr/wdata  command payload
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata/err/timeout response fields, 0 outside rsp_valid
//   err_count             saturating count of error responses
//   psel/penable/pwrite/paddr/pwdata  APB request
//   prdata/pready/pslverr APB completer returns
module apb_master_8bit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [7:0]            err_count,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0]      err_cnt_inc_c;
  logic                  cmd_accept_c;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
`else
  // TIMEOUT only matters when the timeout feature is built in
  logic [31:0]           timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
`endif

  // Gated by preset so every output reads 0 while reset is held
  assign cmd_ready    = !preset && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_ACCESS) && pready));
  assign cmd_accept_c = cmd_valid && cmd_ready;

  assign err_cnt_inc_c = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q
                                                      : err_cnt_q + ERR_W'(1);

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_d        = wait_q;
    rsp_timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_c) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_d    = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          if (pslverr) begin
            err_cnt_d = err_cnt_inc_c;
          end
          if (cmd_accept_c) begin
            // Back-to-back: psel stays high, new SETUP follows directly
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          // wait_q counts earlier low cycles; this is the TIMEOUT-th one
          if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = ST_IDLE;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            err_cnt_d     = err_cnt_inc_c;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
`endif
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_q        <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_q        <= wait_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_cnt_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_8bit.sv
// Bench for apb_master_8bit: directed plan cases, random transfers with
// random wait states and errors, error-count saturation, stuck-pready
// behaviour (with or without the timeout build) and reset mid-transfer.
module tb_apb_master_8bit;

  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned TO_CYC = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [7:0]    err_count;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  apb_master_8bit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO_CYC)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .err_count(err_count),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          write;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    int          waits;
    bit          err;
    logic [7:0]  rdata;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected response for the next cycle, and the model error counter
  bit         pend_v = 0;
  logic [7:0] pend_rdata = '0;
  bit         pend_err = 0;
  bit         pend_to = 0;
  int         exp_errs = 0;
  logic [2:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(bit w, logic [2:0] a, logic [7:0] wd, int ws, bit e, logic [7:0] rd);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = wd; t.waits = ws; t.err = e; t.rdata = rd;
    return t;
  endfunction

  // Advance one cycle, then check the response outputs against the model
  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
    if (pend_v) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(pend_rdata));
      chk("rsp_err", 32'(rsp_err), 32'(pend_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(pend_to));
      if (pend_err && exp_errs < 255) exp_errs++;
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      chk("rsp_rdata_idle", 32'(rsp_rdata), 32'd0);
      chk("rsp_err_idle", 32'(rsp_err), 32'd0);
      chk("rsp_timeout_idle", 32'(rsp_timeout), 32'd0);
      chk("err_count", 32'(err_count), 32'(exp_errs));
    end
    pend_v = 0;
  endtask

  task automatic chk_req(input string tag, input txn_t t, input bit en);
    chk({tag, "_psel"}, 32'(psel), 32'd1);
    chk({tag, "_penable"}, 32'(penable), 32'(en));
    chk({tag, "_paddr"}, 32'(paddr), 32'(t.addr));
    chk({tag, "_pwrite"}, 32'(pwrite), 32'(t.write));
    if (t.write) chk({tag, "_pwdata"}, 32'(pwdata), 32'(t.wdata));
  endtask

  // Called at a negedge where the DUT can accept; returns at the negedge of
  // the completing ACCESS cycle with pready=1 driven.
  task automatic issue(input txn_t t);
    cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata;
    #1;
    chk("cmd_ready_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 3'($urandom); cmd_wdata = 8'($urandom);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = 8'($urandom);
    #1;
    chk_req("setup", t, 1'b0);
    chk("cmd_ready_setup", 32'(cmd_ready), 32'd0);
    for (int w = 0; w < t.waits; w++) begin
      tick();
      pready = 1'b0; pslverr = 1'($urandom); prdata = 8'($urandom);
      #1;
      chk_req("wait", t, 1'b1);
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd0);
    end
    tick();
    pready = 1'b1; pslverr = t.err; prdata = t.rdata;
    #1;
    chk_req("access", t, 1'b1);
    chk("cmd_ready_done", 32'(cmd_ready), 32'd1);
    pend_v = 1; pend_rdata = t.write ? 8'h00 : t.rdata; pend_err = t.err; pend_to = 0;
    last_addr = t.addr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      cmd_valid = 1'b0;
      pready = 1'($urandom); pslverr = 1'($urandom);
      #1;
      chk("idle_psel", 32'(psel), 32'd0);
      chk("idle_penable", 32'(penable), 32'd0);
      chk("idle_paddr_hold", 32'(paddr), 32'(last_addr));
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
    chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    chk({tag, "_paddr"}, 32'(paddr), 32'd0);
    chk({tag, "_pwdata"}, 32'(pwdata), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    txn_t t;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    @(negedge pclk);
    #1;
    chk_all_zero("reset");
    @(negedge pclk);
    preset = 1'b0;
    idle(1);

    // Zero-wait write
    issue(mk(1, 3'b010, 8'h5A, 0, 0, 8'hFF));
    idle(2);
    // Read with three wait states
    issue(mk(0, 3'b011, 8'h00, 3, 0, 8'h30));
    idle(1);
    // Write ending in pslverr; earlier pslverr during waits is ignored
    issue(mk(1, 3'b001, 8'h11, 2, 1, 8'h00));
    idle(2);
    // Back-to-back writes
    issue(mk(1, 3'd3, 8'hA0, 0, 0, 8'h00));
    issue(mk(1, 3'd3, 8'h30, 0, 0, 8'h00));
    idle(2);

    // Random transfers, randomly back-to-back
    for (int i = 0; i < 40; i++) begin
      t = mk(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
             ($urandom_range(0, 3) == 0), 8'($urandom));
      issue(t);
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Drive err_count into saturation
    for (int i = 0; i < 260; i++) issue(mk(1, 3'($urandom), 8'($urandom), 0, 1, 8'h00));
    idle(2);
    chk("err_count_sat", 32'(err_count), 32'd255);

    // pready stuck low
    t = mk(0, 3'd5, 8'h00, 0, 0, 8'h00);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = t.addr;
    #1;
    chk("stuck_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; pready = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int k = 1; k <= int'(TO_CYC); k++) begin
      tick();
      pready = 1'b0; pslverr = 1'($urandom);
      #1;
      chk_req("stuck_access", t, 1'b1);
      chk("stuck_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    pend_v = 1; pend_rdata = 8'h00; pend_err = 1; pend_to = 1;
    last_addr = t.addr;
    idle(1);
    issue(mk(1, 3'd6, 8'hC3, 1, 0, 8'h00));
    idle(1);
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      pready = 1'b0; pslverr = 1'($urandom);
      #1;
      chk_req("stuck_access", t, 1'b1);
      chk("stuck_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    #2; preset = 1'b1; exp_errs = 0;
    #1;
    chk_all_zero("stuck_reset");
    tick();
    preset = 1'b0; last_addr = '0;
    idle(1);
`endif

    // Reset during ACCESS of a read
    issue(mk(1, 3'd2, 8'h77, 0, 1, 8'h00));
    idle(1);
    t = mk(0, 3'd7, 8'h00, 0, 0, 8'h00);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = t.addr;
    #1;
    tick();
    cmd_valid = 1'b0; pready = 1'b0;
    tick();
    pready = 1'b0; pslverr = 1'b1; prdata = 8'h99;
    #1;
    chk_req("pre_reset_access", t, 1'b1);
    #1; preset = 1'b1; exp_errs = 0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    preset = 1'b0; pslverr = 1'b0; last_addr = '0;
    idle(1);
    issue(mk(0, 3'd4, 8'h00, 1, 0, 8'h5C));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_8bit.md
# apb_master_8bit

APB initiator that turns single register commands into APB3 transfers on the bus shared by `timer_counter_8bit` and other 8-bit peripherals. Each accepted command produces one SETUP/ACCESS sequence honouring `pready` wait states. The result returns as a one-cycle response carrying read data and the error status. The block replaces hand-driven `psel`/`penable` sequencing in benches and in the SoC control path.

## Interface
- `DATA_WIDTH`, 8, `pwdata`/`prdata`/command data width
- `ADDR_WIDTH`, 3, `paddr`/command address width
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready` low before abort (≥2; used only with the timeout feature)

Ports:
- `pclk` in 1: sole clock, rising edge
- `preset` in 1: asynchronous, active-high reset
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: command accepted on the edge where `cmd_valid && cmd_ready`
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ADDR_WIDTH: target register
- `cmd_wdata` in DATA_WIDTH: write data
- `rsp_valid` out 1: one-cycle completion pulse, no backpressure
- `rsp_rdata` out DATA_WIDTH: read data (0 for writes and aborts)
- `rsp_err` out 1: `pslverr` seen at completion, or timeout
- `rsp_timeout` out 1: transfer aborted by timeout
- `err_count` out 8: saturating count of responses with `rsp_err=1`
- `psel`, `penable`, `pwrite` out 1 each: APB control
- `paddr` out ADDR_WIDTH and `pwdata` out DATA_WIDTH: APB address and data
- `prdata` in DATA_WIDTH, `pready` in 1, `pslverr` in 1: APB completer returns

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset enters IDLE.
- `cmd_ready` = (IDLE) or (ACCESS and `pready`). It is combinational on `pready`.
- IDLE, command accepted: latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata`, then go to SETUP. Without a command, stay in IDLE.
- SETUP: `psel=1`, `penable=0`. Always move to ACCESS next.
- ACCESS: `psel=1`, `penable=1`.
  - `pready=0`: stay in ACCESS.
  - `pready=1`: the transfer completes. Capture `prdata` (reads only) and `pslverr`.
  - After completion, go to SETUP if a new command is accepted on the same edge (back-to-back, `psel` stays high), otherwise go to IDLE.
- `pwrite`, `paddr` and `pwdata` are stable from SETUP through the completing ACCESS cycle. They hold their last value after the transfer.
- `rsp_valid` is high for exactly one cycle after each completion or abort. `rsp_*` fields are valid only while `rsp_valid` is high and are 0 otherwise.
- `pslverr` is ignored in any cycle without `pready=1` in ACCESS.
- `err_count` increments on each `rsp_valid && rsp_err` and saturates at 255.

## Timing
- Reset value of every output is 0. The FSM is in IDLE after reset.
- `preset` asserted mid-transfer: all outputs clear immediately, the pending command is dropped, and no response is issued.
- Zero-wait transfer:
  - edge 0: accept
  - cycle 1: SETUP
  - cycle 2: ACCESS with `pready=1`
  - cycle 3: `rsp_valid`
- Each `pready`-low ACCESS cycle adds one cycle of latency.
- Back-to-back throughput is one transfer per 2 cycles.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to ACCESS and counts ACCESS cycles with `pready=0`.
  - If `pready` is low for `TIMEOUT` consecutive ACCESS cycles, the transfer aborts after the `TIMEOUT`-th cycle. The FSM goes to IDLE with `psel=penable=0`.
  - The abort response has `rsp_valid=1`, `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`, and `err_count` increments.
  - `cmd_ready` stays 0 on the abort edge.
- Undefined: no counter. ACCESS waits indefinitely and `rsp_timeout` is tied to 0.

## Test plan
- Write with `cmd_addr=3'b010`, `cmd_wdata=8'h5A`, `pready` tied 1 -> `paddr=2`, `pwdata=8'h5A` in cycles 1–2. `rsp_valid` in cycle 3 with `rsp_err=0` and `rsp_rdata=0`. The timer TDR reads back `8'h5A`.
- Read `cmd_addr=3'b011` with `pready` low for 3 ACCESS cycles, `prdata=8'h30` on the ready cycle -> ACCESS lasts 4 cycles. `rsp_valid` at cycle 6 with `rsp_rdata=8'h30`. Address and control are stable throughout.
- Write with `pslverr=1` and `pready=1` -> `rsp_err=1`, `rsp_timeout=0`, `err_count` 0→1. A `pslverr` pulse with `pready=0` in an earlier cycle is ignored.
- `APB_MASTER_TIMEOUT_EN`, `TIMEOUT=16`, `pready` stuck 0 -> abort after 16 ACCESS cycles with `rsp_err=1` and `rsp_timeout=1`. `psel` drops and the next command is accepted from IDLE. Without the macro, after 100 cycles the transfer is still in ACCESS and no response has been issued.
- Two commands back-to-back (write `8'hA0` to addr 3, then write `8'h30` to addr 3) with `pready=1` -> `psel` high for 4 consecutive cycles, `penable` pattern 0,1,0,1, and two `rsp_valid` pulses 2 cycles apart.
- `preset` asserted during ACCESS of a read -> all outputs 0 within the same cycle, no `rsp_valid`, `err_count=0`. A command issued after release completes normally.
